// File: rtl/elevator_call_dispatcher.sv
// Registers floor calls and issues collective (same-direction-first) target requests to the elevator controller.
// Optional REQ timeout compiled in with `define ELEVATOR_REQ_TIMEOUT_EN.
module elevator_call_dispatcher #(
  parameter int unsigned REQ_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] call_btn,
  input  logic [1:0] current_floor,
  input  logic       stopped,
  input  logic       door_open,
  input  logic       emergency_stop,
  output logic [1:0] target_floor,
  output logic       up_request,
  output logic       down_request,
  output logic [3:0] pending,
  output logic       busy
);

  localparam int unsigned NUM_FLOORS = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_MOVE,
    S_DOOR,
    S_HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] target_q, target_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic       busy_q, busy_d;
  logic       dir_q, dir_d;

  logic [3:0] floor_mask, masked, clr;
  logic       has_above, has_below, sel_dir;
  logic [1:0] lo_above, hi_below, sel_floor;

`ifdef ELEVATOR_REQ_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_LAST = 4'(REQ_TIMEOUT - 1);
  logic [3:0] cnt_q, cnt_d;
`else
  localparam int unsigned unused_req_timeout = REQ_TIMEOUT;
`endif

  // Candidate targets: nearest pending floor above and below, current floor excluded
  always_comb begin
    floor_mask = 4'b0001 << current_floor;
    masked     = pending_q & ~floor_mask;
    has_above  = 1'b0;
    has_below  = 1'b0;
    lo_above   = 2'd0;
    hi_below   = 2'd0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (masked[i] && (2'(i) > current_floor)) begin
        has_above = 1'b1;
        lo_above  = 2'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (masked[i] && (2'(i) < current_floor)) begin
        has_below = 1'b1;
        hi_below  = 2'(i);
      end
    end
    if (dir_q == 1'b0) begin
      sel_floor = has_above ? lo_above : hi_below;
      sel_dir   = !has_above;
    end else begin
      sel_floor = has_below ? hi_below : lo_above;
      sel_dir   = has_below;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dir_d    = dir_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    clr      = 4'b0000;
`ifdef ELEVATOR_REQ_TIMEOUT_EN
    cnt_d    = 4'd0;
`endif
    case (state_q)
      S_IDLE: begin
        if (emergency_stop) begin
          state_d = S_HOLD;
        end else if (stopped && pending_q[current_floor]) begin
          clr = floor_mask;
        end else if (stopped && (masked != 4'b0000)) begin
          state_d  = S_REQ;
          target_d = sel_floor;
          dir_d    = sel_dir;
          up_d     = sel_floor > current_floor;
          down_d   = sel_floor < current_floor;
        end
      end
      S_REQ: begin
        if (emergency_stop) begin
          state_d = S_HOLD;
        end else if (!stopped) begin
          state_d = S_MOVE;
`ifdef ELEVATOR_REQ_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_IDLE;
        end else begin
          up_d   = up_q;
          down_d = down_q;
          cnt_d  = cnt_q + 4'd1;
        end
`else
        end else begin
          up_d   = up_q;
          down_d = down_q;
        end
`endif
      end
      S_MOVE: begin
        if (emergency_stop) begin
          state_d = S_HOLD;
        end else if (door_open) begin
          clr     = 4'b0001 << target_q;
          state_d = S_DOOR;
        end
      end
      S_DOOR: begin
        if (emergency_stop) begin
          state_d = S_HOLD;
        end else if (!door_open) begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (!emergency_stop && stopped) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Serve clear takes priority over a simultaneous press of the same button
    pending_d = (pending_q | call_btn) & ~clr;
    busy_d    = state_d != S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= 4'b0000;
      target_q  <= 2'd0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      busy_q    <= 1'b0;
      dir_q     <= 1'b0;
`ifdef ELEVATOR_REQ_TIMEOUT_EN
      cnt_q     <= 4'd0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      up_q      <= up_d;
      down_q    <= down_d;
      busy_q    <= busy_d;
      dir_q     <= dir_d;
`ifdef ELEVATOR_REQ_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign target_floor = target_q;
  assign up_request   = up_q;
  assign down_request = down_q;
  assign pending      = pending_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Directed self-checking bench for elevator_call_dispatcher; the bench plays the controller role.
module tb_elevator_call_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] call_btn;
  logic [1:0] current_floor;
  logic       stopped;
  logic       door_open;
  logic       emergency_stop;
  logic [1:0] target_floor;
  logic       up_request;
  logic       down_request;
  logic [3:0] pending;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;

  elevator_call_dispatcher #(.REQ_TIMEOUT(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .call_btn      (call_btn),
    .current_floor (current_floor),
    .stopped       (stopped),
    .door_open     (door_open),
    .emergency_stop(emergency_stop),
    .target_floor  (target_floor),
    .up_request    (up_request),
    .down_request  (down_request),
    .pending       (pending),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a trip from MOVE through door cycle back to IDLE at floor f
  task automatic finish_trip(input logic [1:0] f);
    stopped = 1'b0; step(1);
    current_floor = f; door_open = 1'b1; step(1);
    door_open = 1'b0; stopped = 1'b1; step(1);
  endtask

  task automatic test_reset;
    reset = 1'b1; call_btn = 4'b0000; current_floor = 2'd0;
    stopped = 1'b1; door_open = 1'b0; emergency_stop = 1'b0;
    step(2);
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL reset_pending got %b want 0000", pending); end
    tests_run++; if ({up_request, down_request, busy} !== 3'b000) begin tests_failed++; $display("FAIL reset_ctrl got %b want 000", {up_request, down_request, busy}); end
    tests_run++; if (target_floor !== 2'd0) begin tests_failed++; $display("FAIL reset_target got %0d want 0", target_floor); end
    reset = 1'b0; step(1);
  endtask

  task automatic test_basic_up;
    current_floor = 2'd0; call_btn = 4'b1000; step(1);
    call_btn = 4'b0000;
    tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL up_pending_set got %b want 1000", pending); end
    tests_run++; if (up_request !== 1'b0) begin tests_failed++; $display("FAIL up_no_early_req got %b want 0", up_request); end
    step(1);
    tests_run++; if ({target_floor, up_request, down_request, busy} !== {2'd3, 3'b101}) begin tests_failed++; $display("FAIL up_req got t=%0d u=%b d=%b b=%b want t=3 u=1 d=0 b=1", target_floor, up_request, down_request, busy); end
    step(1);
    tests_run++; if (up_request !== 1'b1) begin tests_failed++; $display("FAIL up_req_held got %b want 1", up_request); end
    stopped = 1'b0; step(1);
    tests_run++; if ({up_request, busy} !== 2'b01) begin tests_failed++; $display("FAIL up_move got u=%b b=%b want u=0 b=1", up_request, busy); end
    current_floor = 2'd3; door_open = 1'b1; step(1);
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL up_serve_clear got %b want 0000", pending); end
    door_open = 1'b0; stopped = 1'b1; step(1);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL up_back_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_collective;
    current_floor = 2'd1; call_btn = 4'b1001; step(1);
    call_btn = 4'b0000; step(1);
    tests_run++; if ({target_floor, up_request, down_request} !== {2'd3, 2'b10}) begin tests_failed++; $display("FAIL coll_first got t=%0d u=%b d=%b want t=3 u=1 d=0", target_floor, up_request, down_request); end
    stopped = 1'b0; step(1);
    current_floor = 2'd3; door_open = 1'b1; step(1);
    tests_run++; if (pending !== 4'b0001) begin tests_failed++; $display("FAIL coll_after_serve got %b want 0001", pending); end
    door_open = 1'b0; stopped = 1'b1; step(2);
    tests_run++; if ({target_floor, up_request, down_request} !== {2'd0, 2'b01}) begin tests_failed++; $display("FAIL coll_second got t=%0d u=%b d=%b want t=0 u=0 d=1", target_floor, up_request, down_request); end
    finish_trip(2'd0);
    // dir is now down: from floor 1 with 1001 pending, floor 0 wins
    current_floor = 2'd1; call_btn = 4'b1001; step(1);
    call_btn = 4'b0000; step(1);
    tests_run++; if ({target_floor, up_request, down_request} !== {2'd0, 2'b01}) begin tests_failed++; $display("FAIL coll_dir_down got t=%0d u=%b d=%b want t=0 u=0 d=1", target_floor, up_request, down_request); end
    finish_trip(2'd0);
    tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL coll_remaining got %b want 1000", pending); end
    step(1);
    tests_run++; if ({target_floor, up_request, down_request} !== {2'd3, 2'b10}) begin tests_failed++; $display("FAIL coll_reverse_up got t=%0d u=%b d=%b want t=3 u=1 d=0", target_floor, up_request, down_request); end
    finish_trip(2'd3);
  endtask

  task automatic test_serve_in_place;
    current_floor = 2'd2; call_btn = 4'b0100; step(1);
    call_btn = 4'b0000;
    tests_run++; if (pending !== 4'b0100) begin tests_failed++; $display("FAIL sip_set got %b want 0100", pending); end
    step(1);
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL sip_clear got %b want 0000", pending); end
    tests_run++; if ({up_request, down_request, busy} !== 3'b000) begin tests_failed++; $display("FAIL sip_no_req got %b want 000", {up_request, down_request, busy}); end
    step(2);
    tests_run++; if ({up_request, down_request, busy} !== 3'b000) begin tests_failed++; $display("FAIL sip_still_idle got %b want 000", {up_request, down_request, busy}); end
  endtask

  task automatic test_emergency;
    current_floor = 2'd0; call_btn = 4'b1000; step(1);
    call_btn = 4'b0000; step(1);
    stopped = 1'b0; step(1);
    current_floor = 2'd1; emergency_stop = 1'b1; step(1);
    tests_run++; if ({up_request, down_request, busy} !== 3'b001) begin tests_failed++; $display("FAIL emg_hold got u=%b d=%b b=%b want 0 0 1", up_request, down_request, busy); end
    tests_run++; if (pending !== 4'b1000) begin tests_failed++; $display("FAIL emg_pending got %b want 1000", pending); end
    stopped = 1'b1; step(1);
    tests_run++; if ({up_request, busy} !== 2'b01) begin tests_failed++; $display("FAIL emg_held got u=%b b=%b want 0 1", up_request, busy); end
    emergency_stop = 1'b0; step(1);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL emg_release got busy=%b want 0", busy); end
    step(1);
    tests_run++; if ({target_floor, up_request, down_request} !== {2'd3, 2'b10}) begin tests_failed++; $display("FAIL emg_reissue got t=%0d u=%b d=%b want t=3 u=1 d=0", target_floor, up_request, down_request); end
    finish_trip(2'd3);
  endtask

  task automatic test_timeout;
    current_floor = 2'd0; call_btn = 4'b0010; step(1);
    call_btn = 4'b0000; step(1);
    tests_run++; if ({target_floor, up_request} !== {2'd1, 1'b1}) begin tests_failed++; $display("FAIL to_req got t=%0d u=%b want t=1 u=1", target_floor, up_request); end
`ifdef ELEVATOR_REQ_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      step(1);
      tests_run++; if (up_request !== 1'b1) begin tests_failed++; $display("FAIL to_hold_%0d got %b want 1", k, up_request); end
    end
    step(1);
    tests_run++; if ({up_request, busy} !== 2'b00) begin tests_failed++; $display("FAIL to_drop got u=%b b=%b want 0 0", up_request, busy); end
    step(1);
    tests_run++; if ({target_floor, up_request} !== {2'd1, 1'b1}) begin tests_failed++; $display("FAIL to_reissue got t=%0d u=%b want t=1 u=1", target_floor, up_request); end
`else
    step(20);
    tests_run++; if ({up_request, busy} !== 2'b11) begin tests_failed++; $display("FAIL to_wait_forever got u=%b b=%b want 1 1", up_request, busy); end
`endif
    finish_trip(2'd1);
    tests_run++; if (pending !== 4'b0000) begin tests_failed++; $display("FAIL to_cleanup got %b want 0000", pending); end
  endtask

  task automatic test_reset_mid_trip;
    current_floor = 2'd0; call_btn = 4'b1010; step(1);
    call_btn = 4'b0000; step(1);
    tests_run++; if ({target_floor, up_request} !== {2'd1, 1'b1}) begin tests_failed++; $display("FAIL rst_pre_req got t=%0d u=%b want t=1 u=1", target_floor, up_request); end
    stopped = 1'b0; step(1);
    reset = 1'b1; #1;
    tests_run++; if ({target_floor, up_request, down_request, pending, busy} !== 9'd0) begin tests_failed++; $display("FAIL rst_async got t=%0d u=%b d=%b p=%b b=%b want all 0", target_floor, up_request, down_request, pending, busy); end
    stopped = 1'b1; step(2);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1);
      tests_run++; if ({up_request, down_request, pending, busy} !== 7'd0) begin tests_failed++; $display("FAIL rst_quiet_%0d got u=%b d=%b p=%b b=%b want all 0", k, up_request, down_request, pending, busy); end
    end
    call_btn = 4'b0100; step(1);
    call_btn = 4'b0000; step(1);
    tests_run++; if ({target_floor, up_request, down_request} !== {2'd2, 2'b10}) begin tests_failed++; $display("FAIL rst_new_call got t=%0d u=%b d=%b want t=2 u=1 d=0", target_floor, up_request, down_request); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_up();
    test_collective();
    test_serve_in_place();
    test_emergency();
    test_timeout();
    test_reset_mid_trip();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/elevator_call_dispatcher.md
# elevator_call_dispatcher

Request-side companion to the elevator FSM controller. Registers floor call buttons and picks the next target floor with a collective (same-direction-first) policy. Drives `target_floor`, `up_request` and `down_request` into the controller, and watches the controller's `stopped` and `door_open` outputs to know when each call has been served. The controller consumes the three request outputs; this block is their only source.

## Interface
- `REQ_TIMEOUT`, default 8: cycles to wait in REQ for the controller to start moving. Legal range 1..15. Only used when the timeout is compiled in.

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `call_btn` in 4: per-floor call buttons, bit i = floor i. Level-sampled every cycle.
- `current_floor` in 2: floor position, shared with the controller.
- `stopped` in 1: from the controller; 1 when the car is not moving.
- `door_open` in 1: from the controller.
- `emergency_stop` in 1: same signal the controller sees.
- `target_floor` out 2: floor requested from the controller. Registered.
- `up_request` out 1: registered.
- `down_request` out 1: registered.
- `pending` out 4: outstanding calls. Registered.
- `busy` out 1: 1 whenever the FSM is not in IDLE. Registered.

## Operation
- **Pending register**
  - `pending[i]` is set in any cycle where `call_btn[i]` = 1.
  - It is cleared only by a serve event (see below).
  - In a clear cycle, clear wins over set for that bit. A button still held afterwards re-registers the call.
- **Direction register `dir`** (0 = up, 1 = down). It is updated only on IDLE→REQ.
- **Target selection**, from `pending` with the `current_floor` bit masked out:
  - dir = up and any bit above `current_floor`: target = lowest pending floor above.
  - Otherwise, any bit below: target = highest pending floor below, and dir ← down.
  - Symmetric rules apply for dir = down.
  - At most one of `up_request` / `down_request` is ever 1.
- **States**
  - **IDLE**
    - `emergency_stop` = 1: go to HOLD.
    - Else, if `stopped` = 1 and `pending[current_floor]` = 1: clear that bit (served in place, no request issued).
    - Else, if masked `pending` ≠ 0 and `stopped` = 1: latch `target_floor` and `dir`, assert `up_request` (target > current) or `down_request` (target < current), go to REQ.
  - **REQ**
    - Hold the request until `stopped` = 0, then drop the request and go to MOVE.
    - `emergency_stop` = 1: drop the request and go to HOLD.
  - **MOVE**
    - Requests are 0.
    - On the first cycle with `door_open` = 1: clear `pending[target_floor]` and go to DOOR.
    - `emergency_stop` = 1: go to HOLD.
  - **DOOR**
    - On `door_open` = 0: go to IDLE.
    - `emergency_stop` = 1: go to HOLD.
  - **HOLD**
    - Requests are 0 and `pending` is retained.
    - When `emergency_stop` = 0 and `stopped` = 1: go to IDLE, which reselects a target.
- `target_floor` changes only on the IDLE→REQ transition. It is stable through REQ, MOVE and DOOR; the controller requires this while moving.
- Calls arriving during REQ, MOVE or DOOR are recorded but never retarget the current trip.
- **Reset**, asynchronous, applicable mid-trip:
  - State ← IDLE.
  - `pending`, `target_floor`, `up_request`, `down_request`, `busy` ← 0.
  - `dir` ← up.

## Timing
- **Call to request:** `call_btn` sampled at edge N sets `pending` at N. The request and `target_floor` are valid after edge N+1, provided `stopped` = 1 and the state is IDLE.
- **Request to movement:** the controller leaves IDLE one edge after sampling the request, and `stopped` falls one edge later. REQ therefore normally lasts 2 cycles.
- **Serve to clear:** the `pending` bit clears at the edge following the first `door_open` = 1 sample.
- **Serve in place:** a call at the current floor while idle clears 2 edges after the press, with no request asserted.
- **Emergency:** requests drop at the first edge after `emergency_stop` is sampled high.

## Configuration
- **`ELEVATOR_REQ_TIMEOUT_EN` defined**
  - A 4-bit counter runs in REQ.
  - If `stopped` is still 1 after `REQ_TIMEOUT` cycles, the request drops and the FSM returns to IDLE, then reissues per selection on the next cycle.
  - `pending` is unaffected.
- **`ELEVATOR_REQ_TIMEOUT_EN` undefined:** REQ waits indefinitely for `stopped` = 0. No counter is synthesized.

## Test plan
- **Basic trip up:** reset, `current_floor` = 0, pulse `call_btn` = 4'b1000.
  - `pending` = 1000, then `target_floor` = 3 and `up_request` = 1.
  - `up_request` = 0 after `stopped` falls.
  - `pending` = 0000 one cycle after `door_open` rises.
- **Collective order:** `current_floor` = 1, dir = up, `pending` = 1001.
  - First target is 3 with `up_request`.
  - After the serve, target 0 with `down_request`, and dir = down.
- **Serve in place:** idle at `current_floor` = 2, `call_btn` = 0100 for 1 cycle.
  - `pending[2]` clears within 2 cycles.
  - `up_request` / `down_request` stay 0.
- **Emergency mid-trip:** in MOVE toward 3, raise `emergency_stop`.
  - Requests stay 0, `busy` = 1, `pending[3]` is retained.
  - After release with `stopped` = 1, `up_request` reasserts with `target_floor` = 3.
- **Timeout** (macro defined, `REQ_TIMEOUT` = 8): hold `stopped` = 1 during REQ.
  - The request drops after 8 cycles, the FSM returns to IDLE and the request reasserts.
  - With the macro undefined, the request stays high indefinitely.
- **Reset mid-trip:** assert `reset` during MOVE with `pending` = 1010.
  - All outputs are 0 immediately.
  - No request appears after release until a new `call_btn` press.
